// File: rtl/spi_master_sequencer_if.sv
// Byte request/response handshake between a client and spi_master_sequencer.
// Signal names are seen from the sequencer's side.
interface spi_master_sequencer_if;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       i_cpol;
    logic       i_cpha;
    logic [7:0] o_data;
    logic       o_done;

    modport master (
        output i_valid, i_data, i_cpol, i_cpha,
        input  o_ready, o_data, o_done
    );

    modport slave (
        input  i_valid, i_data, i_cpol, i_cpha,
        output o_ready, o_data, o_done
    );
endinterface

// File: rtl/spi_master_sequencer.sv
// SPI master transaction sequencer: drives SCLK/CS_n/MOSI and steers an external
// 8-bit universal shift register (load / left shift / hold) for one byte per request.
module spi_master_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    spi_master_sequencer_if.slave        bus,
    output logic                         o_sclk,
    output logic                         o_cs_n,
    output logic                         o_mosi,
    input  logic                         i_miso,
    output logic                         o_sr_s0,
    output logic                         o_sr_s1,
    output logic [7:0]                   o_sr_parallel,
    output logic                         o_sr_serial,
    input  logic [7:0]                   i_sr_parallel
);

    if (CLK_DIV < 2) begin : g_clk_div_check
        $error("spi_master_sequencer: CLK_DIV must be at least 2");
    end

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEAD,
        S_XFER,
        S_TRAIL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       edge_q, edge_d;
    logic             phase_q, phase_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [7:0]       data_q, data_d;
    logic             miso_q, miso_d;
    logic [7:0]       rdata_q, rdata_d;

    logic cnt_last;
    logic sample_edge;
    logic shift_edge;
    logic cs_n;

    assign cnt_last = (cnt_q == CNT_LAST);
    // The edge about to happen is edge_q+1; it is a leading edge when that number is odd.
    assign sample_edge = ~edge_q[0] ^ cpha_q;
    assign shift_edge  = ~sample_edge & (edge_q != 5'd0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edge_q  <= 5'd0;
            phase_q <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            data_q  <= 8'h00;
            miso_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            phase_q <= phase_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            data_q  <= data_d;
            miso_q  <= miso_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        phase_d = phase_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        data_d  = data_q;
        miso_d  = miso_q;
        rdata_d = rdata_q;
        o_sr_s0 = 1'b0;
        o_sr_s1 = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    data_d  = bus.i_data;
                    cpol_d  = bus.i_cpol;
                    cpha_d  = bus.i_cpha;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                o_sr_s0 = 1'b1;
                o_sr_s1 = 1'b1;
                cnt_d   = '0;
                edge_d  = 5'd0;
                phase_d = 1'b0;
                state_d = S_LEAD;
            end
            S_LEAD: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) state_d = S_XFER;
            end
            S_XFER: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    phase_d = ~phase_q;
                    edge_d  = edge_q + 5'd1;
                    if (sample_edge) miso_d = i_miso;
                    if (shift_edge)  o_sr_s1 = 1'b1;
                    if (edge_q == 5'd15) state_d = S_TRAIL;
                end
            end
            S_TRAIL: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    // With CPHA=1 the bit sampled on edge 16 still has to be shifted in.
                    if (cpha_q) o_sr_s1 = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rdata_d = i_sr_parallel;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cs_n          = (state_q == S_IDLE) || (state_q == S_DONE);
    assign o_cs_n        = cs_n;
    assign o_sclk        = cpol_q ^ phase_q;
    assign o_mosi        = ~cs_n & i_sr_parallel[7];
    assign o_sr_parallel = data_q;
    assign o_sr_serial   = miso_q;

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_done  = (state_q == S_DONE);
    // The final CPHA=1 shift lands on DONE entry, so DONE passes the register straight through.
    assign bus.o_data  = (state_q == S_DONE) ? i_sr_parallel : rdata_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: shift-register and SPI-slave models, a cycle-level
// timing model derived from the transfer schedule, and directed transfers in all modes.
module tb_spi_master_sequencer;

    localparam int D         = 2;
    localparam int T_DONE    = 2 + 18 * D;
    localparam int T_TRAIL   = 2 + 17 * D;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       o_sclk, o_cs_n, o_mosi, i_miso;
    logic       o_sr_s0, o_sr_s1, o_sr_serial;
    logic [7:0] o_sr_parallel, i_sr_parallel;

    spi_master_sequencer_if bus ();

    spi_master_sequencer #(.CLK_DIV(D)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .bus           (bus),
        .o_sclk        (o_sclk),
        .o_cs_n        (o_cs_n),
        .o_mosi        (o_mosi),
        .i_miso        (i_miso),
        .o_sr_s0       (o_sr_s0),
        .o_sr_s1       (o_sr_s1),
        .o_sr_parallel (o_sr_parallel),
        .o_sr_serial   (o_sr_serial),
        .i_sr_parallel (i_sr_parallel)
    );

    always #5 i_clk = ~i_clk;

    // Downstream universal shift register: {s1,s0} 11 load, 10 left shift, 01 right shift, 00 hold.
    logic [7:0] sr_q = 8'h00;
    always @(posedge i_clk) begin
        case ({o_sr_s1, o_sr_s0})
            2'b11:   sr_q <= o_sr_parallel;
            2'b10:   sr_q <= {sr_q[6:0], o_sr_serial};
            2'b01:   sr_q <= {o_sr_serial, sr_q[7:1]};
            default: sr_q <= sr_q;
        endcase
    end
    assign i_sr_parallel = sr_q;

    logic       loop_en  = 1'b0;
    logic       slave_miso = 1'b0;
    logic [7:0] slave_tx = 8'h00;
    assign i_miso = loop_en ? o_mosi : slave_miso;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_shift_cycle(input int t, input bit cpha);
        for (int k = 1; k <= 16; k++)
            if (t == 1 + (k + 1) * D)
                return cpha ? ((k % 2 == 1) && (k >= 3)) : (k % 2 == 0);
        return cpha && (t == 1 + 18 * D);
    endfunction

    function automatic int shifts_before(input int t, input bit cpha);
        int n = 0;
        for (int u = 2; u < t; u++)
            if (is_shift_cycle(u, cpha)) n++;
        return n;
    endfunction

    function automatic int edges_seen(input int t);
        int n;
        if (t < 2 + 2 * D) return 0;
        n = (t - 2) / D - 1;
        return (n > 16) ? 16 : n;
    endfunction

    // Model and per-transfer statistics
    bit         in_flight = 1'b0;
    int         t = 0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00, held = 8'h00, slave_rx = 8'h00, last_data = 8'h00;
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    logic       prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [1:0] prev_mode = 2'b00, mode_now;
    int acc_cyc = 0, last_spacing = 0, accept_cnt = 0, done_seen = 0, last_done_t = 0;
    int cs_low_cnt = 0, rise_cnt = 0, fall_cnt = 0, shift_cnt = 0, mosi_bad = 0;
    int slave_edges = 0, illegal_cnt = 0, double_cnt = 0;
    bit shift_in_trail = 1'b0;

    task automatic check_idle();
        check("idle_ready", bus.o_ready, 1'b1);
        check("idle_cs_n", o_cs_n, 1'b1);
        check("idle_sclk", o_sclk, m_cpol);
        check("idle_s1s0", {o_sr_s1, o_sr_s0}, 2'b00);
        check("idle_mosi", o_mosi, 1'b0);
        check("idle_done", bus.o_done, 1'b0);
        check("idle_data", bus.o_data, held);
    endtask

    always @(negedge i_clk) begin
        int n, j, idx;
        bit sh;
        cyc++;
        mode_now = {o_sr_s1, o_sr_s0};
        if (mode_now == 2'b01) illegal_cnt++;
        if (mode_now == 2'b10 && prev_mode == 2'b10) double_cnt++;
        if (bus.o_done === 1'b1) done_seen++;

        if (!i_rst_n) begin
            in_flight = 1'b0;
            m_cpol    = 1'b0;
            held      = 8'h00;
            check_idle();
        end else if (in_flight) begin
            t++;
            n  = edges_seen(t);
            j  = shifts_before(t, m_cpha);
            sh = is_shift_cycle(t, m_cpha);
            check("ready", bus.o_ready, 1'b0);
            check("cs_n", o_cs_n, (t == T_DONE));
            check("sclk", o_sclk, m_cpol ^ n[0]);
            check("s1s0", mode_now, (t == 1) ? 2'b11 : (sh ? 2'b10 : 2'b00));
            check("sr_parallel", o_sr_parallel, m_tx);
            check("done", bus.o_done, (t == T_DONE));
            if (sh) check("sr_serial", o_sr_serial, m_rx[7 - j]);
            if (t >= 2)
                check("mosi", o_mosi, (t == T_DONE) ? 1'b0 : ((j < 8) ? m_tx[7 - j] : m_rx[7]));

            if (!o_cs_n) cs_low_cnt++;
            if (mode_now == 2'b10) begin
                shift_cnt++;
                if (t >= T_TRAIL) shift_in_trail = 1'b1;
            end

            // SPI slave: samples MOSI on its capture edge, drives MISO on the other edge.
            if (t >= 2 && t < T_DONE && o_sclk !== prev_sclk) begin
                slave_edges++;
                if (o_sclk) rise_cnt++; else fall_cnt++;
                if ((slave_edges % 2 == 1) == !m_cpha) begin
                    if (o_mosi !== prev_mosi) mosi_bad++;
                    slave_rx = {slave_rx[6:0], o_mosi};
                end
            end
            if (m_cpha) idx = (slave_edges == 0) ? -1 : (slave_edges - 1) / 2;
            else        idx = slave_edges / 2;
            slave_miso = (idx >= 0 && idx < 8) ? slave_tx[7 - idx] : 1'b0;

            if (t == T_DONE) begin
                check("data", bus.o_data, m_rx);
                check("slave_rx", slave_rx, m_tx);
                held        = m_rx;
                last_data   = bus.o_data;
                last_done_t = t;
                in_flight   = 1'b0;
            end
        end else begin
            check_idle();
            if (bus.i_valid) begin
                in_flight      = 1'b1;
                t              = 0;
                m_tx           = bus.i_data;
                m_cpol         = bus.i_cpol;
                m_cpha         = bus.i_cpha;
                m_rx           = loop_en ? bus.i_data : slave_tx;
                last_spacing   = cyc - acc_cyc;
                acc_cyc        = cyc;
                accept_cnt++;
                cs_low_cnt     = 0;
                rise_cnt       = 0;
                fall_cnt       = 0;
                shift_cnt      = 0;
                mosi_bad       = 0;
                shift_in_trail = 1'b0;
                slave_edges    = 0;
                slave_rx       = 8'h00;
                slave_miso     = bus.i_cpha ? 1'b0 : slave_tx[7];
            end
        end
        prev_mode = mode_now;
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
    end

    task automatic start(input logic [7:0] b, input logic cpol, input logic cpha,
                         input logic [7:0] stx, input logic loop);
        @(posedge i_clk); #1;
        slave_tx    = stx;
        loop_en     = loop;
        bus.i_data  = b;
        bus.i_cpol  = cpol;
        bus.i_cpha  = cpha;
        bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 4 * T_DONE && !seen; i++) begin
            @(negedge i_clk);
            seen = bus.o_done;
        end
        #1;
        check("wait_done", seen, 1'b1);
    endtask

    initial begin
        int base, done_before;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_cpol  = 1'b0;
        bus.i_cpha  = 1'b0;
        i_rst_n     = 1'b1;
        #2 i_rst_n  = 1'b0;
        #1;
        check("rst_ready", bus.o_ready, 1'b1);
        check("rst_cs_n", o_cs_n, 1'b1);
        check("rst_sclk", o_sclk, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        check("rst_data", bus.o_data, 8'h00);
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Mode 0, MISO looped back to MOSI
        start(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done();
        check("m0_data", last_data, 8'hA5);
        check("m0_done_cycle", last_done_t, 38);
        check("m0_rises", rise_cnt, 8);
        check("m0_falls", fall_cnt, 8);
        check("m0_mosi_stable", mosi_bad, 0);

        // Mode 3 against a slave shifting out 0x3C
        start(8'hC3, 1'b1, 1'b1, 8'h3C, 1'b0);
        wait_done();
        check("m3_data", last_data, 8'h3C);
        check("m3_slave_rx", slave_rx, 8'hC3);
        check("m3_shifts", shift_cnt, 8);
        check("m3_shift_in_trail", shift_in_trail, 1'b1);
        @(posedge i_clk); #1;
        check("m3_idle_sclk", o_sclk, 1'b1);

        // Modes 1 and 2
        start(8'h01, 1'b0, 1'b1, 8'h96, 1'b0);
        wait_done();
        check("m1_slave_rx", slave_rx, 8'h01);
        check("m1_data", last_data, 8'h96);
        check("m1_cs_low", cs_low_cnt, 37);
        start(8'h80, 1'b1, 1'b0, 8'h69, 1'b0);
        wait_done();
        check("m2_slave_rx", slave_rx, 8'h80);
        check("m2_data", last_data, 8'h69);
        check("m2_cs_low", cs_low_cnt, 37);

        // i_valid held high across two transfers; inputs change during the first
        base = accept_cnt;
        @(posedge i_clk); #1;
        slave_tx    = 8'h5E;
        loop_en     = 1'b0;
        bus.i_data  = 8'h11;
        bus.i_cpol  = 1'b0;
        bus.i_cpha  = 1'b0;
        bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_data  = 8'h22;
        bus.i_cpol  = 1'b1;
        bus.i_cpha  = 1'b1;
        for (int i = 0; i < 4 * T_DONE && accept_cnt < base + 2; i++) begin
            @(posedge i_clk); #1;
        end
        bus.i_valid = 1'b0;
        check("vh_accepts", accept_cnt - base, 2);
        check("vh_spacing", last_spacing, 39);
        wait_done();
        check("vh_data", last_data, 8'h5E);
        check("vh_slave_rx", slave_rx, 8'h22);

        // Reset right after SCLK edge 5
        start(8'h33, 1'b0, 1'b0, 8'hF0, 1'b0);
        repeat (13) @(posedge i_clk);
        #1;
        check("pre_rst_sclk", o_sclk, 1'b1);
        check("pre_rst_cs_n", o_cs_n, 1'b0);
        done_before = done_seen;
        i_rst_n = 1'b0;
        #1;
        check("arst_cs_n", o_cs_n, 1'b1);
        check("arst_sclk", o_sclk, 1'b0);
        check("arst_ready", bus.o_ready, 1'b1);
        check("arst_s1s0", {o_sr_s1, o_sr_s0}, 2'b00);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        check("arst_no_done", done_seen, done_before);
        start(8'h5A, 1'b0, 1'b0, 8'hA3, 1'b0);
        wait_done();
        check("post_rst_data", last_data, 8'hA3);
        check("post_rst_slave_rx", slave_rx, 8'h5A);

        repeat (3) @(posedge i_clk);
        #1;
        check("no_s0s1_10", illegal_cnt, 0);
        check("single_cycle_shift", double_cnt, 0);
        check("done_total", done_seen, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
